// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline hazard/sequencing controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding and the register-index width shared by
// the interface, the load-use comparator and the top.
package hazard_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // RUN: normal flow; MD_WAIT: mul/div in flight; MD_ISSUE: result ready.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MD_WAIT  = 2'b01,
        MD_ISSUE = 2'b10
    } hz_state_t;

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_if.sv
// Purpose: bundle of pipeline-side signals between the core and hazard_ctrl.
// Latency: n/a (wiring only).
// Backpressure: n/a; the stall controls themselves are the pipeline's backpressure.
//
// Ports (slave = hazard_ctrl view):
//   in : rs1_idr, rs2_idr, uses_rs1_idr, uses_rs2_idr, md_idr,
//        rd_exr, MemRead_exr, RegWrite_exr, branch_taken_exr, perf_clr
//   out: pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_abort,
//        md_busy, stall_cycles[CNT_W]
// The master modport is the pipeline/core side.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_pkg::*;

    // ID-stage instruction
    reg_idx_t          rs1_idr;
    reg_idx_t          rs2_idr;
    logic              uses_rs1_idr;
    logic              uses_rs2_idr;
    logic              md_idr;
    // EX-stage instruction
    reg_idx_t          rd_exr;
    logic              MemRead_exr;
    logic              RegWrite_exr;
    logic              branch_taken_exr;
    // performance counter control
    logic              perf_clr;
    // pipeline register controls
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_bubble;
    // mul/div unit controls
    logic              md_start;
    logic              md_abort;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_cycles;

    modport slave (
        input  rs1_idr, rs2_idr, uses_rs1_idr, uses_rs2_idr, md_idr,
        input  rd_exr, MemRead_exr, RegWrite_exr, branch_taken_exr, perf_clr,
        output pc_en, ifid_en, ifid_flush, idex_bubble,
        output md_start, md_abort, md_busy, stall_cycles
    );

    modport master (
        output rs1_idr, rs2_idr, uses_rs1_idr, uses_rs2_idr, md_idr,
        output rd_exr, MemRead_exr, RegWrite_exr, branch_taken_exr, perf_clr,
        input  pc_en, ifid_en, ifid_flush, idex_bubble,
        input  md_start, md_abort, md_busy, stall_cycles
    );

endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl_lu_detect.sv
// Purpose: combinational load-use hazard comparator (ID sources vs EX load dest).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the result feeds the stall decode.
//
// Ports:
//   rs1_idr_i, rs2_idr_i, uses_rs1_idr_i, uses_rs2_idr_i : ID source operands
//   rd_exr_i, mem_read_exr_i, reg_write_exr_i             : EX destination
//   lu_o                                                  : load-use hazard
module hazard_ctrl_lu_detect
    import hazard_ctrl_pkg::*;
(
    input  reg_idx_t rs1_idr_i,
    input  reg_idx_t rs2_idr_i,
    input  logic     uses_rs1_idr_i,
    input  logic     uses_rs2_idr_i,
    input  reg_idx_t rd_exr_i,
    input  logic     mem_read_exr_i,
    input  logic     reg_write_exr_i,
    output logic     lu_o
);

    logic ex_load_live;
    logic src_match;

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign ex_load_live = mem_read_exr_i & reg_write_exr_i & (rd_exr_i != '0);

    // Only operands the ID instruction actually reads count; an unused field
    // can hold arbitrary encoding bits that happen to match.
    assign src_match = (uses_rs1_idr_i & (rs1_idr_i == rd_exr_i)) |
                       (uses_rs2_idr_i & (rs2_idr_i == rd_exr_i));

    assign lu_o = ex_load_live & src_match;

endmodule : hazard_ctrl_lu_detect

// File: rtl/hazard_ctrl.sv
// Purpose: 5-stage pipeline hazard controller: load-use stall, mul/div stall, branch flush, stall perf counter.
// Latency: stall/flush controls are combinational from same-cycle inputs; mul/div stall lasts MD_LAT cycles then one issue cycle.
// Backpressure: drives pc_en/ifid_en low to hold PC and IF/ID; inserts bubbles into ID/EX while holding.
//
// Ports:
//   clk, rst   : core clock (rising edge), asynchronous active-high reset
//   hz (slave) : ID/EX operand info in, pipeline and mul/div controls out,
//                saturating stall_cycles counter out
// Parameters: MD_LAT mul/div latency (legal 2..15), CNT_W counter width
// (must match the CNT_W of the connected interface).
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam logic [3:0]       MD_CNT_INIT = 4'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] STALL_MAX   = '1;

    hz_state_t        state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             md_busy_q;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic lu;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_abort;

    hazard_ctrl_lu_detect u_lu_detect (
        .rs1_idr_i       (hz.rs1_idr),
        .rs2_idr_i       (hz.rs2_idr),
        .uses_rs1_idr_i  (hz.uses_rs1_idr),
        .uses_rs2_idr_i  (hz.uses_rs2_idr),
        .rd_exr_i        (hz.rd_exr),
        .mem_read_exr_i  (hz.MemRead_exr),
        .reg_write_exr_i (hz.RegWrite_exr),
        .lu_o            (lu)
    );

    // ------------------------------------------------------------------
    // Next-state and output decode. Priority: branch > load-use > mul/div.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        md_abort    = 1'b0;

        if (hz.branch_taken_exr) begin
            // Wrong-path flush: PC takes the target, IF/ID and ID/EX get NOPs.
            // A pending mul/div belongs to the wrong path, so cancel it.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_d     = RUN;
            if (state_q == MD_WAIT) begin
                md_abort = 1'b1;
            end
        end else begin
            unique case (state_q)
                RUN: begin
                    if (lu) begin
                        // One bubble; afterwards the load value forwards from MEM.
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                    end else if (hz.md_idr) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_bubble = 1'b1;
                        md_start    = 1'b1;
                        cnt_d       = MD_CNT_INIT;
                        state_d     = MD_WAIT;
                    end
                end
                MD_WAIT: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idex_bubble = 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = MD_ISSUE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                MD_ISSUE: begin
                    // The mul/div still sits in ID with md_idr=1; ignoring it
                    // here lets it advance instead of restarting the unit.
                    state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        // Outputs sit at their idle values for the whole reset, independent
        // of whatever the pipeline presents on its inputs meanwhile.
        if (rst) begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
            md_start    = 1'b0;
            md_abort    = 1'b0;
        end
    end

    // Saturating stall counter; clear beats increment.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (hz.perf_clr) begin
            stall_cycles_d = '0;
        end else if (!pc_en && (stall_cycles_q != STALL_MAX)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 4'd0;
            md_busy_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            // Registered copy of "in MD_WAIT" so md_busy is glitch-free.
            md_busy_q      <= (state_d == MD_WAIT);
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_bubble  = idex_bubble;
    assign hz.md_start     = md_start;
    assign hz.md_abort     = md_abort;
    assign hz.md_busy      = md_busy_q;
    assign hz.stall_cycles = stall_cycles_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl (MD_LAT=4, CNT_W=4).
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Backpressure: n/a.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic pc, input logic ifen,
                            input logic fl, input logic bub, input logic st,
                            input logic ab);
        chk({tag, "_pc_en"},       32'(hz.pc_en),       32'(pc));
        chk({tag, "_ifid_en"},     32'(hz.ifid_en),     32'(ifen));
        chk({tag, "_ifid_flush"},  32'(hz.ifid_flush),  32'(fl));
        chk({tag, "_idex_bubble"}, 32'(hz.idex_bubble), 32'(bub));
        chk({tag, "_md_start"},    32'(hz.md_start),    32'(st));
        chk({tag, "_md_abort"},    32'(hz.md_abort),    32'(ab));
    endtask

    task automatic idle();
        hz.rs1_idr          = '0;
        hz.rs2_idr          = '0;
        hz.uses_rs1_idr     = 1'b0;
        hz.uses_rs2_idr     = 1'b0;
        hz.md_idr           = 1'b0;
        hz.rd_exr           = '0;
        hz.MemRead_exr      = 1'b0;
        hz.RegWrite_exr     = 1'b0;
        hz.branch_taken_exr = 1'b0;
        hz.perf_clr         = 1'b0;
    endtask

    // Load in EX writing rd, ID instruction reading rs1/rs2.
    task automatic set_ops(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                           input logic [4:0] r2, input logic u2, input logic rw);
        hz.rd_exr       = rd;
        hz.MemRead_exr  = 1'b1;
        hz.RegWrite_exr = rw;
        hz.rs1_idr      = r1;
        hz.uses_rs1_idr = u1;
        hz.rs2_idr      = r2;
        hz.uses_rs2_idr = u2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset: outputs idle regardless of inputs ----------
        rst = 1'b1;
        idle();
        set_ops(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        hz.branch_taken_exr = 1'b1;
        #2;
        chk_ctrl("rst", 1, 1, 0, 0, 0, 0);
        chk("rst_md_busy", 32'(hz.md_busy), 32'd0);
        chk("rst_stall", 32'(hz.stall_cycles), 32'd0);
        tick();
        idle();
        rst = 1'b0;
        #1;
        chk_ctrl("idle", 1, 1, 0, 0, 0, 0);

        // ---------------- load-use: one stall cycle -----------------------
        tick();
        set_ops(5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b1);
        #1;
        chk_ctrl("lu", 0, 0, 0, 1, 0, 0);
        tick();
        chk("lu_stall_cnt", 32'(hz.stall_cycles), 32'd1);
        idle();
        #1;
        chk_ctrl("lu_after", 1, 1, 0, 0, 0, 0);

        // ---------------- no-stall cases ----------------------------------
        set_ops(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1);
        #1;
        chk("x0_pc_en", 32'(hz.pc_en), 32'd1);
        set_ops(5'd7, 5'd7, 1'b0, 5'd3, 1'b1, 1'b1);
        #1;
        chk("unused_rs1_pc_en", 32'(hz.pc_en), 32'd1);
        set_ops(5'd7, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
        #1;
        chk("no_regwrite_pc_en", 32'(hz.pc_en), 32'd1);
        tick();
        chk("no_stall_cnt", 32'(hz.stall_cycles), 32'd1);

        // ---------------- branch beats load-use ---------------------------
        set_ops(5'd5, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1);
        hz.branch_taken_exr = 1'b1;
        #1;
        chk_ctrl("br_lu", 1, 1, 1, 1, 0, 0);
        tick();
        chk("br_lu_stall_cnt", 32'(hz.stall_cycles), 32'd1);

        // ---------------- branch beats mul/div start ----------------------
        idle();
        hz.md_idr           = 1'b1;
        hz.branch_taken_exr = 1'b1;
        #1;
        chk_ctrl("br_md", 1, 1, 1, 1, 0, 0);
        tick();
        chk("br_md_busy", 32'(hz.md_busy), 32'd0);

        // ---------------- mul/div sequence --------------------------------
        idle();
        hz.md_idr = 1'b1;
        #1;
        chk_ctrl("md_start", 0, 0, 0, 1, 1, 0);
        chk("md_start_busy", 32'(hz.md_busy), 32'd0);
        for (int i = 1; i < MD_LAT; i++) begin
            tick();
            chk($sformatf("md_wait%0d_busy", i), 32'(hz.md_busy), 32'd1);
            chk_ctrl($sformatf("md_wait%0d", i), 0, 0, 0, 1, 0, 0);
        end
        tick();
        // MD_ISSUE: md_idr still high and a load-use pattern present, both ignored
        set_ops(5'd6, 5'd6, 1'b1, 5'd0, 1'b0, 1'b1);
        #1;
        chk("md_issue_busy", 32'(hz.md_busy), 32'd0);
        chk_ctrl("md_issue", 1, 1, 0, 0, 0, 0);
        chk("md_stall_cnt", 32'(hz.stall_cycles), 32'd5);
        tick();
        idle();
        #1;
        chk("md_done_cnt", 32'(hz.stall_cycles), 32'd5);
        chk("md_done_busy", 32'(hz.md_busy), 32'd0);

        // ---------------- branch in 2nd MD_WAIT cycle ---------------------
        hz.md_idr = 1'b1;
        tick();
        tick();
        hz.branch_taken_exr = 1'b1;
        #1;
        chk_ctrl("br_wait", 1, 1, 1, 1, 0, 1);
        tick();
        idle();
        #1;
        chk_ctrl("br_wait_after", 1, 1, 0, 0, 0, 0);
        chk("br_wait_busy", 32'(hz.md_busy), 32'd0);
        chk("br_wait_cnt", 32'(hz.stall_cycles), 32'd7);

        // ---------------- async reset mid-MD_WAIT -------------------------
        hz.md_idr = 1'b1;
        tick();
        chk("pre_rst_busy", 32'(hz.md_busy), 32'd1);
        chk("pre_rst_cnt", 32'(hz.stall_cycles), 32'd8);
        #1;
        rst = 1'b1;
        #1;
        chk_ctrl("arst", 1, 1, 0, 0, 0, 0);
        chk("arst_busy", 32'(hz.md_busy), 32'd0);
        chk("arst_cnt", 32'(hz.stall_cycles), 32'd0);
        tick();
        idle();
        rst = 1'b0;
        tick();
        chk("post_rst_pc_en", 32'(hz.pc_en), 32'd1);
        chk("post_rst_busy", 32'(hz.md_busy), 32'd0);
        chk("post_rst_cnt", 32'(hz.stall_cycles), 32'd0);

        // ---------------- counter saturation and clear --------------------
        set_ops(5'd9, 5'd9, 1'b1, 5'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        chk("sat_cnt", 32'(hz.stall_cycles), 32'd15);
        chk("sat_pc_en", 32'(hz.pc_en), 32'd0);
        hz.perf_clr = 1'b1;
        tick();
        chk("clr_cnt", 32'(hz.stall_cycles), 32'd0);
        idle();
        tick();
        chk("clr_hold_cnt", 32'(hz.stall_cycles), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage core. It sits beside the forwarding unit and drives the PC, IF/ID and ID/EX register controls:
- load-use stalls, which forwarding cannot cover;
- multi-cycle stalls for the fixed-latency mul/div unit;
- wrong-path flushes on taken branches resolved in EX.

It also keeps a saturating stall-cycle performance counter.

## Interface
- MD_LAT, 4, mul/div latency in cycles; legal range 2..15
- CNT_W, 16, width of stall performance counter
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- rs1_idr  in  5  rs1 of instruction in ID
- rs2_idr  in  5  rs2 of instruction in ID
- uses_rs1_idr  in  1  ID instruction reads rs1
- uses_rs2_idr  in  1  ID instruction reads rs2
- md_idr  in  1  ID instruction is mul/div
- rd_exr  in  5  destination of instruction in EX
- MemRead_exr  in  1  EX instruction is a load
- RegWrite_exr  in  1  EX instruction writes the register file
- branch_taken_exr  in  1  branch/jump in EX resolved taken
- perf_clr  in  1  synchronous clear of stall_cycles
- pc_en  out  1  PC register load enable
- ifid_en  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a NOP
- md_start  out  1  one-cycle start pulse to mul/div unit
- md_abort  out  1  one-cycle abort pulse to mul/div unit
- md_busy  out  1  registered; high while in MD_WAIT
- stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

## Operation
- **Load-use condition (lu):**
  - MemRead_exr & RegWrite_exr & (rd_exr != 0), and
  - (uses_rs1_idr & rs1_idr == rd_exr) | (uses_rs2_idr & rs2_idr == rd_exr).
- **FSM states:** RUN, MD_WAIT, MD_ISSUE. A 4-bit down-counter cnt is used in MD_WAIT.
- **Priority each cycle:** branch > load-use > mul/div.
- **Branch (any state, branch_taken_exr=1):**
  - Outputs: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
  - Next state is RUN.
  - If in MD_WAIT: md_abort=1 for that cycle.
- **RUN, lu=1:**
  - Outputs: pc_en=0, ifid_en=0, idex_bubble=1.
  - Stay in RUN. Exactly one stall cycle; forwarding covers the load from MEM afterwards.
- **RUN, md_idr=1, lu=0, no branch:**
  - Outputs: stall (pc_en=0, ifid_en=0, idex_bubble=1) and md_start=1.
  - cnt <= MD_LAT-1; next state MD_WAIT.
- **MD_WAIT, no branch:**
  - Outputs: stall as above.
  - If cnt==1, next state MD_ISSUE; else cnt <= cnt-1.
- **MD_ISSUE:**
  - md_idr and lu are ignored. No stall: pc_en=1, ifid_en=1, idex_bubble=0.
  - The mul/div instruction advances to EX with its result ready.
  - Next state RUN.
- **Otherwise:** pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, md_start=0, md_abort=0.
- **stall_cycles:**
  - perf_clr has priority and sets it to 0.
  - Else it increments on every cycle with pc_en=0, saturating at 2^CNT_W-1 with no wrap.

## Timing
- **Flush and load-use:** all flush and load-use controls are combinational from the same-cycle inputs, so they act at the next clock edge.
- **Mul/div stall length:** exactly MD_LAT cycles with pc_en=0, counted from the md_start cycle, followed by one MD_ISSUE cycle.
- **Reset:** while rst=1, and immediately on assertion:
  - state=RUN, cnt=0, md_busy=0, stall_cycles=0;
  - pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0, md_start=0, md_abort=0.
- **Reset mid-MD_WAIT:** returns to RUN. md_abort is not pulsed; the mul/div unit is reset by the same rst.
- **Branch and lu together:** the flush wins, and no stall is counted.
- **Branch and md_idr together in RUN:** the flush wins, and md_start is not pulsed.
- **rd_exr == 0:** never stalls.

## Structure
- A shared package/header holds:
  - state encodings: RUN=2'b00, MD_WAIT=2'b01, MD_ISSUE=2'b10;
  - the register-index width of 5.
- One natural sub-module, lu_detect: the combinational load-use comparator. It is reusable by any future dual-issue variant.
- Everything else stays in hazard_ctrl: the FSM, cnt, the output decode and the perf counter.

## Test plan
- **Load-use:** load x5 in EX (MemRead_exr=1, RegWrite_exr=1, rd_exr=5), add with rs2_idr=5, uses_rs2_idr=1 -> one cycle with pc_en=0, ifid_en=0, idex_bubble=1; stall_cycles=1.
- **Load to x0:** rd_exr=0, rs1_idr=0, uses_rs1_idr=1 -> no stall; uses_rs1_idr=0 with matching index -> no stall.
- **Mul/div sequence:** md_idr=1, MD_LAT=4 -> md_start pulse in the first cycle; pc_en=0 for 4 cycles; md_busy high for 3 cycles; MD_ISSUE with pc_en=1 while md_idr is still 1; no restart.
- **Branch during MD_WAIT:** branch_taken_exr in the 2nd MD_WAIT cycle -> md_abort=1, ifid_flush=1, idex_bubble=1; next cycle state RUN and pc_en=1.
- **Simultaneous events:** branch_taken_exr with lu=1 -> flush only, pc_en=1, stall_cycles unchanged. Async rst mid-MD_WAIT -> all outputs at reset values without a clock edge.
- **Counter saturation:** CNT_W=4, hold lu=1 for 20 cycles -> stall_cycles stops at 15; perf_clr -> 0 next edge.
